// File: rtl/filters_pkg.sv
// Shared types and constant helpers for the saturating channel scheduler.
package filters_pkg;

    // Output slot occupancy.
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_e;

    // Width of a channel index; never narrower than one bit.
    function automatic int chan_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // Largest value representable in an ow-bit signed word.
    function automatic int sat_max(input int ow);
        return (1 << (ow - 1)) - 1;
    endfunction

    // Smallest value representable in an ow-bit signed word.
    function automatic int sat_min(input int ow);
        return -(1 << (ow - 1));
    endfunction

endpackage

// File: rtl/filters_rr_arb.sv
// Pure round-robin arbiter: search starts one past the last grant and wraps.
module filters_rr_arb
    import filters_pkg::*;
#(
    parameter  int N   = 4,
    localparam int CHW = chan_w(N)
) (
    input  logic [N-1:0]   req_i,
    input  logic [CHW-1:0] last_i,
    output logic [N-1:0]   gnt_o,
    output logic [CHW-1:0] idx_o,
    output logic           any_o
);

    int c;

    // First requester found after last_i (in circular order) wins.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        c     = 0;
        for (int k = 1; k <= N; k++) begin
            c = (int'(last_i) + k) % N;
            if (!any_o && req_i[c]) begin
                any_o    = 1'b1;
                gnt_o[c] = 1'b1;
                idx_o    = CHW'(c);
            end
        end
    end

endmodule

// File: rtl/filters_sat.sv
// Combinational signed narrowing from IW to OW bits with clip flag.
module filters_sat
    import filters_pkg::*;
#(
    parameter int IW = 10,
    parameter int OW = 9
) (
    input  logic signed [IW-1:0] x_i,
    output logic signed [OW-1:0] y_o,
    output logic                 clip_o
);

    localparam int MAXV = sat_max(OW);
    localparam int MINV = sat_min(OW);
    localparam logic signed [OW-1:0] MAX_C = MAXV[OW-1:0];
    localparam logic signed [OW-1:0] MIN_C = MINV[OW-1:0];

    logic fits;

    // The value fits when every dropped bit is a copy of the sign bit.
    always_comb begin
        fits   = (x_i[IW-2:OW-1] == {(IW-OW){x_i[IW-1]}});
        clip_o = !fits;
        if (fits) begin
            y_o = {x_i[IW-1], x_i[OW-2:0]};
        end else if (x_i[IW-1]) begin
            y_o = MIN_C;
        end else begin
            y_o = MAX_C;
        end
    end

endmodule

// File: rtl/filters_sat_sched.sv
// Round-robin time-sharing of one saturator across N requesters, with a
// registered output slot and per-channel sticky clip counters.
module filters_sat_sched
    import filters_pkg::*;
#(
    parameter  int N   = 4,
    parameter  int IW  = 10,
    parameter  int OW  = 9,
    parameter  int CW  = 16,
    localparam int CHW = chan_w(N)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [N-1:0]        req_valid_i,
    input  logic [N*IW-1:0]     req_data_i,
    output logic [N-1:0]        req_ready_o,
    output logic                out_valid_o,
    output logic [OW-1:0]       out_data_o,
    output logic [CHW-1:0]      out_chan_o,
    output logic                out_clip_o,
    input  logic                out_ready_i,
    input  logic [CHW-1:0]      clip_sel_i,
    output logic [CW-1:0]       clip_cnt_o,
    input  logic                clip_clr_i
);

    slot_e                slot_q;
    logic [OW-1:0]        data_q;
    logic [CHW-1:0]       chan_q;
    logic                 clip_q;
    logic [CHW-1:0]       last_q;
    logic [CW-1:0]        cnt_q [N];
    logic [CW-1:0]        cnt_d [N];

    logic [N-1:0]         gnt;
    logic [CHW-1:0]       win_idx;
    logic                 win_any;
    logic signed [IW-1:0] win_data;
    logic signed [OW-1:0] sat_data;
    logic                 sat_clip;
    logic                 slot_free;
    logic                 xfer;

    filters_rr_arb #(.N(N)) u_arb (
        .req_i  (req_valid_i),
        .last_i (last_q),
        .gnt_o  (gnt),
        .idx_o  (win_idx),
        .any_o  (win_any)
    );

    // Route the winning channel's sample to the shared saturator.
    always_comb begin
        win_data = '0;
        for (int i = 0; i < N; i++) begin
            if (win_idx == CHW'(i)) begin
                win_data = req_data_i[i*IW +: IW];
            end
        end
    end

    filters_sat #(.IW(IW), .OW(OW)) u_sat (
        .x_i    (win_data),
        .y_o    (sat_data),
        .clip_o (sat_clip)
    );

    // Ready is withheld during reset even though the slot reads as empty then.
    always_comb begin
        slot_free   = (slot_q == SLOT_EMPTY) || out_ready_i;
        xfer        = win_any && slot_free && !rst_i;
        req_ready_o = xfer ? gnt : '0;
    end

    // Output slot FSM: load on transfer, drain when consumed with no refill.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slot_q <= SLOT_EMPTY;
            data_q <= '0;
            chan_q <= '0;
            clip_q <= 1'b0;
            last_q <= CHW'(N - 1);
        end else if (xfer) begin
            slot_q <= SLOT_FULL;
            data_q <= sat_data;
            chan_q <= win_idx;
            clip_q <= sat_clip;
            last_q <= win_idx;
        end else if ((slot_q == SLOT_FULL) && out_ready_i) begin
            slot_q <= SLOT_EMPTY;
        end
    end

    // Counter next state: saturating increment on clipped grants; clear wins.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = cnt_q[i];
            if (xfer && sat_clip && (win_idx == CHW'(i)) && (cnt_q[i] != '1)) begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
            if (clip_clr_i && (clip_sel_i == CHW'(i))) begin
                cnt_d[i] = '0;
            end
        end
    end

    // Clip counter array.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Combinational counter read; an out-of-range select reads zero.
    always_comb begin
        clip_cnt_o = '0;
        for (int i = 0; i < N; i++) begin
            if (clip_sel_i == CHW'(i)) begin
                clip_cnt_o = cnt_q[i];
            end
        end
    end

    assign out_valid_o = (slot_q == SLOT_FULL);
    assign out_data_o  = data_q;
    assign out_chan_o  = chan_q;
    assign out_clip_o  = clip_q;

endmodule

// File: tb/tb_filters_sat_sched.sv
// Scoreboard bench for filters_sat_sched (N=4, IW=10, OW=9, CW=2).
module tb_filters_sat_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [9:0]  d [4];
    logic [39:0] req_data;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [8:0]  out_data;
    logic [1:0]  out_chan;
    logic        out_clip;
    logic        out_ready;
    logic [1:0]  clip_sel;
    logic [1:0]  clip_cnt;
    logic        clip_clr;

    assign req_data = {d[3], d[2], d[1], d[0]};

    always #5 clk = ~clk;

    filters_sat_sched #(.N(4), .IW(10), .OW(9), .CW(2)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_chan_o  (out_chan),
        .out_clip_o  (out_clip),
        .out_ready_i (out_ready),
        .clip_sel_i  (clip_sel),
        .clip_cnt_o  (clip_cnt),
        .clip_clr_i  (clip_clr)
    );

    typedef struct {
        logic [8:0] data;
        logic [1:0] chan;
        logic       clip;
    } exp_t;

    exp_t sb [$];
    int   n_chk  = 0;
    int   n_pass = 0;
    bit   m_full;
    int   m_last;
    int   m_cnt [4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_full = 1'b0;
        m_last = 3;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    endtask

    // Compare DUT against the model at the negedge, then advance the model.
    task automatic model_step();
        bit         free;
        int         win;
        int         c;
        logic [3:0] exp_rdy;
        logic signed [9:0] s;
        int         v;
        exp_t       e;
        free = !m_full || out_ready;
        win  = -1;
        for (int k = 1; k <= 4; k++) begin
            c = (m_last + k) % 4;
            if (win < 0 && req_valid[c]) win = c;
        end
        exp_rdy = (free && win >= 0) ? (4'b0001 << win) : 4'b0000;
        check("req_ready", req_ready, exp_rdy);
        check("out_valid", out_valid, m_full);
        check("clip_cnt", clip_cnt, m_cnt[clip_sel]);
        if (m_full && sb.size() > 0) begin
            check("out_data", out_data, sb[0].data);
            check("out_chan", out_chan, sb[0].chan);
            check("out_clip", out_clip, sb[0].clip);
            if (out_ready) void'(sb.pop_front());
        end
        if (free && win >= 0) begin
            s = d[win];
            v = s;
            if (v > 255) begin
                e.data = 9'h0FF; e.clip = 1'b1;
            end else if (v < -256) begin
                e.data = 9'h100; e.clip = 1'b1;
            end else begin
                e.data = v[8:0]; e.clip = 1'b0;
            end
            e.chan = 2'(win);
            sb.push_back(e);
            m_last = win;
            m_full = 1'b1;
            if (e.clip && m_cnt[win] < 3) m_cnt[win]++;
        end else if (m_full && out_ready) begin
            m_full = 1'b0;
        end
        if (clip_clr) m_cnt[clip_sel] = 0;
    endtask

    task automatic cycle();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; out_ready = 1'b1;
        clip_sel = '0; clip_clr = 1'b0;
        for (int i = 0; i < 4; i++) d[i] = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        req_valid = 4'hF;
        #1;
        check("rst_valid", out_valid, 1'b0);
        check("rst_data", out_data, 9'h0);
        check("rst_chan", out_chan, 2'h0);
        check("rst_clip", out_clip, 1'b0);
        check("rst_ready", req_ready, 4'h0);
        check("rst_cnt", clip_cnt, 2'h0);
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single channel, in range.
        clip_sel = 2'd2; d[2] = 10'h0FF; req_valid = 4'b0100;
        cycle();
        req_valid = '0;
        cycle();
        check("ch2_data", out_data, 9'h0FF);
        cycle();

        // Channel 1: positive clip, negative clip, in-range negative.
        clip_sel = 2'd1;
        d[1] = 10'h1FF; req_valid = 4'b0010; cycle();
        d[1] = 10'h200; cycle();
        d[1] = 10'h3FF; cycle();
        req_valid = '0; cycle(); cycle();

        // All channels valid, full throughput.
        d[0] = 10'h2AA; d[1] = 10'h050; d[2] = 10'h1C0; d[3] = 10'h3F0;
        req_valid = 4'hF;
        for (int i = 0; i < 12; i++) begin
            clip_sel = 2'(i);
            cycle();
        end

        // Backpressure for 5 cycles, then release.
        out_ready = 1'b0;
        repeat (5) cycle();
        out_ready = 1'b1;
        repeat (4) cycle();
        req_valid = '0;
        cycle();

        // Clear every counter.
        clip_clr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            clip_sel = 2'(i);
            cycle();
        end
        clip_clr = 1'b0;

        // Counter ceiling on channel 0.
        clip_sel = 2'd0; d[0] = 10'h1FF; req_valid = 4'b0001;
        repeat (5) cycle();
        req_valid = '0;
        check("ceiling", clip_cnt, 2'd3);
        cycle();

        // Clear coincident with a clipping transfer.
        req_valid = 4'b0001; clip_clr = 1'b1;
        cycle();
        req_valid = '0; clip_clr = 1'b0;
        check("clr_wins", clip_cnt, 2'd0);
        cycle(); cycle();

        // Randomised traffic.
        for (int i = 0; i < 60; i++) begin
            for (int j = 0; j < 4; j++) d[j] = 10'($urandom);
            req_valid = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            clip_sel  = 2'($urandom);
            clip_clr  = ($urandom_range(0, 9) == 0);
            cycle();
        end
        clip_clr = 1'b0;

        // Asynchronous reset while the slot is full.
        req_valid = 4'hF; out_ready = 1'b0;
        cycle(); cycle();
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", out_valid, 1'b0);
        check("arst_data", out_data, 9'h0);
        check("arst_chan", out_chan, 2'h0);
        check("arst_clip", out_clip, 1'b0);
        check("arst_ready", req_ready, 4'h0);
        model_reset();
        @(posedge clk); #3;
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        check("first_grant", req_ready, 4'b0001);
        repeat (6) cycle();
        req_valid = '0;
        repeat (2) cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
